// File: rtl/bcd_seq_conv.sv
// Sequential 32-bit binary to 8-digit packed BCD converter, shift-and-add-3, one bit per clock.
// Optional build macro BCD_SAT_EN: values above 99,999,999 read out as 32'h99999999 instead of the low 8 digits.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; bcd_out/ovf hold the last result
// S_SHIFT | 32 correct-and-shift iterations; busy high
// S_DONE  | one-cycle done pulse; start ignored
module bcd_seq_conv (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd_out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [39:0] acc_q;
  logic [31:0] sr_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] bcd_q;
  logic        ovf_q;

  logic [39:0] acc_adj;
  logic [39:0] acc_d;
  logic [31:0] bcd_d;
  logic        ovf_d;

  // All ten digits are corrected independently; no carry crosses a digit boundary.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_d = {acc_adj[38:0], sr_q[31]};
    ovf_d = |acc_d[39:32];
`ifdef BCD_SAT_EN
    bcd_d = ovf_d ? 32'h9999_9999 : acc_d[31:0];
`else
    bcd_d = acc_d[31:0];
`endif
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_q    <= bin_in;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q   <= acc_d;
          sr_q    <= {sr_q[30:0], 1'b0};
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: vector table, scoreboard on done, and multi-cycle corner sequences.
module tb_bcd_seq_conv;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic        ovf;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_pass;
  int   n_total;
  int   cyc;

  bcd_seq_conv dut (
    .CLK    (CLK),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out),
    .ovf    (ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Saturation only changes the digits, never the flag.
  function automatic exp_t expect_of(input logic [31:0] raw, input logic o);
    exp_t e;
    e.bcd = raw;
    e.ovf = o;
`ifdef BCD_SAT_EN
    if (o) e.bcd = 32'h9999_9999;
`endif
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] v);
    longint unsigned x;
    logic [31:0]     r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return expect_of(r, v > 32'd99999999);
  endfunction

  always @(negedge CLK) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("bcd_out", {8'h0, bcd_out}, {8'h0, e.bcd});
        check("ovf", {39'h0, ovf}, {39'h0, e.ovf});
        check("busy_with_done", {39'h0, busy}, 40'h0);
      end
    end
  end

  task automatic do_conv(input logic [31:0] v, input exp_t e);
    int k;
    @(negedge CLK);
    start  = 1'b1;
    bin_in = v;
    sb_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    check("busy_after_accept", {39'h0, busy}, 40'h1);
    start  = 1'b0;
    bin_in = $urandom;
    k = 0;
    while (!done && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check("latency", 40'(k), 40'd32);
    @(negedge CLK);
    check("done_width", {38'h0, done, busy}, 40'h0);
    bin_in = ~v;
    repeat (3) @(negedge CLK);
    check("hold", {7'h0, bcd_out, ovf}, {7'h0, e.bcd, e.ovf});
  endtask

  initial begin
    int   k;
    int   t[3];
    int   nd;
    exp_t e;
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{32'd12345678,  32'h1234_5678, 1'b0};
    vecs[1] = '{32'd0,         32'h0000_0000, 1'b0};
    vecs[2] = '{32'd99999999,  32'h9999_9999, 1'b0};
    vecs[3] = '{32'd100000000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h9496_7295, 1'b1};
    vecs[5] = '{32'd5,         32'h0000_0005, 1'b0};
    vecs[6] = '{32'd90210,     32'h0009_0210, 1'b0};
    vecs[7] = '{32'd123456789, 32'h2345_6789, 1'b1};

    start  = 1'b0;
    bin_in = 32'h0;
    rst    = 1'b0;
    #1;
    check("reset_outputs", {6'h0, busy, done, bcd_out}, 40'h0);
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_outputs", {5'h0, busy, done, ovf, bcd_out}, 40'h0);

    for (int i = 0; i < 8; i++) do_conv(vecs[i].bin, expect_of(vecs[i].bcd, vecs[i].ovf));

    for (int i = 0; i < 4; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (i < 2) r = r % 32'd100000000;
      do_conv(r, model(r));
    end

    // start during busy is ignored, and bin_in changes have no effect
    @(negedge CLK);
    start  = 1'b1;
    bin_in = 32'd42;
    sb_q.push_back(expect_of(32'h0000_0042, 1'b0));
    @(posedge CLK);
    @(negedge CLK);
    start  = 1'b0;
    bin_in = 32'hDEAD_BEEF;
    repeat (9) @(negedge CLK);
    start  = 1'b1;
    bin_in = 32'd7;
    @(negedge CLK);
    start  = 1'b0;
    bin_in = 32'h5555_5555;
    k = 10;
    while (!done && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check("busy_start_latency", 40'(k), 40'd32);
    repeat (40) @(negedge CLK);
    check("busy_start_hold", {7'h0, busy, bcd_out}, {8'h0, 32'h0000_0042});

    // start held high: done pulses 34 cycles apart
    @(negedge CLK);
    start  = 1'b1;
    bin_in = 32'd2024;
    for (int i = 0; i < 3; i++) sb_q.push_back(expect_of(32'h0000_2024, 1'b0));
    nd = 0;
    k  = 0;
    while (nd < 3 && k < 150) begin
      @(negedge CLK);
      k++;
      if (done) begin
        t[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    check("held_start_pulses", 40'(nd), 40'd3);
    if (nd == 3) begin
      check("throughput_1", 40'(t[1] - t[0]), 40'd34);
      check("throughput_2", 40'(t[2] - t[1]), 40'd34);
    end
    repeat (40) @(negedge CLK);
    check("held_start_idle", {39'h0, busy}, 40'h0);

    // reset in the middle of a conversion
    do_conv(32'd12345678, expect_of(32'h1234_5678, 1'b0));
    @(negedge CLK);
    start  = 1'b1;
    bin_in = 32'd55;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (15) @(posedge CLK);
    #1 rst = 1'b0;
    #1;
    check("midreset_outputs", {6'h0, busy, done, bcd_out}, 40'h0);
    check("midreset_ovf", {39'h0, ovf}, 40'h0);
    repeat (3) @(negedge CLK);
    rst = 1'b1;
    repeat (40) @(negedge CLK);
    check("after_reset_idle", {7'h0, busy, bcd_out}, 40'h0);
    do_conv(32'd55, expect_of(32'h0000_0055, 1'b0));

    check("scoreboard_empty", 40'(sb_q.size()), 40'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
